// File: rtl/charmatrix_pkg.sv
// Shared definitions for the character-matrix engine: FSM encoding,
// buffer entry layout, blank character and per-channel colour scaling.
package charmatrix_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        LOAD  = 2'd2,
        SEND  = 2'd3
    } state_t;

    localparam logic [7:0] BLANK_CHAR = 8'h20;

    typedef struct packed {
        logic [7:0] ch;
        logic [3:0] color;
    } cell_t;

    // One 8-bit channel dimmed by a logical right shift; channels never interact
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [2:0] sh);
        return c >> sh;
    endfunction

endpackage

// File: rtl/charmatrix_if.sv
// Text-write handshake and pixel stream of the character-matrix engine.
interface charmatrix_if #(
    parameter int COLOR_W = 24
);
    logic               wr_valid;
    logic               wr_ready;
    logic [7:0]         wr_char;
    logic [3:0]         wr_color;
    logic [COLOR_W-1:0] px_data;
    logic               px_valid;
    logic               px_ready;
    logic               px_last;

    // Producer of text / consumer of pixels
    modport master (
        output wr_valid, wr_char, wr_color, px_ready,
        input  wr_ready, px_data, px_valid, px_last
    );

    // The engine itself
    modport slave (
        input  wr_valid, wr_char, wr_color, px_ready,
        output wr_ready, px_data, px_valid, px_last
    );
endinterface

// File: rtl/charmatrix_textbuf.sv
// Text/colour buffer: wrap or scroll writes, single-cycle clear, one read port.
module charmatrix_textbuf
    import charmatrix_pkg::*;
#(
    parameter int NUM_CHARS = 4,
    parameter int PTR_W     = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr_en,
    input  logic             i_clear,
    input  logic             i_mode,
    input  logic [7:0]       i_char,
    input  logic [3:0]       i_color,
    input  logic [PTR_W-1:0] i_rd_idx,
    output logic [7:0]       o_rd_char,
    output logic [3:0]       o_rd_color
);
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_CHARS - 1);

    cell_t            r_buf [NUM_CHARS];
    logic [PTR_W-1:0] r_wr_ptr;

    // Buffer update: clear beats a same-cycle write; scroll shifts toward cell 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CHARS; i++) r_buf[i] <= '{ch: BLANK_CHAR, color: 4'd0};
            r_wr_ptr <= '0;
        end else if (i_clear) begin
            for (int i = 0; i < NUM_CHARS; i++) r_buf[i] <= '{ch: BLANK_CHAR, color: 4'd0};
            r_wr_ptr <= '0;
        end else if (i_wr_en) begin
            if (i_mode) begin
                for (int i = 0; i < NUM_CHARS - 1; i++) r_buf[i] <= r_buf[i+1];
                r_buf[NUM_CHARS-1] <= '{ch: i_char, color: i_color};
            end else begin
                r_buf[r_wr_ptr] <= '{ch: i_char, color: i_color};
                r_wr_ptr        <= (r_wr_ptr == LAST_IDX) ? '0 : r_wr_ptr + PTR_W'(1);
            end
        end
    end

    assign o_rd_char  = r_buf[i_rd_idx].ch;
    assign o_rd_color = r_buf[i_rd_idx].color;

endmodule

// File: rtl/charmatrix_engine.sv
// Character-matrix engine: walks every cell, looks up glyph and colour ROMs,
// and streams one dimmed pixel per glyph bit to the LED driver.
module charmatrix_engine
    import charmatrix_pkg::*;
#(
    parameter int NUM_CHARS  = 4,
    parameter int GLYPH_BITS = 35,
    parameter int COLOR_W    = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    charmatrix_if.slave           bus,
    input  logic                  mode,
    input  logic                  clear,
    input  logic [2:0]            bright,
    input  logic                  refresh_req,
    output logic                  busy,
    output logic [7:0]            glyph_addr,
    input  logic [GLYPH_BITS-1:0] glyph_data,
    output logic [3:0]            color_addr,
    input  logic [COLOR_W-1:0]    color_data
);
    localparam int CELL_W = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1;
    localparam int BIT_W  = (GLYPH_BITS > 1) ? $clog2(GLYPH_BITS) : 1;
    localparam int NCH    = COLOR_W / 8;
    localparam logic [CELL_W-1:0] LAST_CELL = CELL_W'(NUM_CHARS - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(GLYPH_BITS - 1);

    state_t                r_state,     w_state_n;
    logic [CELL_W-1:0]     r_cell,      w_cell_n;
    logic [BIT_W-1:0]      r_bit,       w_bit_n;
    logic [GLYPH_BITS-1:0] r_glyph,     w_glyph_n;
    logic [COLOR_W-1:0]    r_color,     w_color_n;
    logic [COLOR_W-1:0]    r_px_data,   w_px_data_n;
    logic                  r_px_valid,  w_px_valid_n;
    logic                  r_px_last,   w_px_last_n;

    logic                  w_wr_en;
    logic [7:0]            w_rd_char;
    logic [3:0]            w_rd_color;
    logic [COLOR_W-1:0]    w_scaled;

    assign bus.wr_ready = !clear;
    assign w_wr_en      = bus.wr_valid && !clear;

    charmatrix_textbuf #(
        .NUM_CHARS (NUM_CHARS),
        .PTR_W     (CELL_W)
    ) u_textbuf (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_wr_en    (w_wr_en),
        .i_clear    (clear),
        .i_mode     (mode),
        .i_char     (bus.wr_char),
        .i_color    (bus.wr_color),
        .i_rd_idx   (r_cell),
        .o_rd_char  (w_rd_char),
        .o_rd_color (w_rd_color)
    );

    // ROM addresses always follow the current cell; they are only sampled in FETCH
    assign glyph_addr = w_rd_char;
    assign color_addr = w_rd_color;

    // Dim the latched colour with the brightness in force at LOAD time
    for (genvar c = 0; c < NCH; c++) begin : g_chan
        assign w_scaled[c*8 +: 8] = scale_chan(r_color[c*8 +: 8], bright);
    end

    assign busy         = (r_state != IDLE);
    assign bus.px_data  = r_px_data;
    assign bus.px_valid = r_px_valid;
    assign bus.px_last  = r_px_last;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cell     <= '0;
            r_bit      <= '0;
            r_glyph    <= '0;
            r_color    <= '0;
            r_px_data  <= '0;
            r_px_valid <= 1'b0;
            r_px_last  <= 1'b0;
        end else begin
            r_state    <= w_state_n;
            r_cell     <= w_cell_n;
            r_bit      <= w_bit_n;
            r_glyph    <= w_glyph_n;
            r_color    <= w_color_n;
            r_px_data  <= w_px_data_n;
            r_px_valid <= w_px_valid_n;
            r_px_last  <= w_px_last_n;
        end
    end

    // Next state: fetch a cell once, then LOAD/SEND each of its glyph bits
    always_comb begin
        w_state_n    = r_state;
        w_cell_n     = r_cell;
        w_bit_n      = r_bit;
        w_glyph_n    = r_glyph;
        w_color_n    = r_color;
        w_px_data_n  = r_px_data;
        w_px_valid_n = r_px_valid;
        w_px_last_n  = r_px_last;
        case (r_state)
            IDLE: begin
                if (refresh_req) begin
                    w_state_n = FETCH;
                    w_cell_n  = '0;
                    w_bit_n   = '0;
                end
            end
            FETCH: begin
                w_glyph_n = glyph_data;
                w_color_n = color_data;
                w_state_n = LOAD;
            end
            LOAD: begin
                w_px_data_n  = r_glyph[r_bit] ? w_scaled : '0;
                w_px_valid_n = 1'b1;
                w_px_last_n  = (r_cell == LAST_CELL) && (r_bit == LAST_BIT);
                w_state_n    = SEND;
            end
            SEND: begin
                if (bus.px_ready) begin
                    w_px_valid_n = 1'b0;
                    w_px_last_n  = 1'b0;
                    if (r_bit != LAST_BIT) begin
                        w_bit_n   = r_bit + BIT_W'(1);
                        w_state_n = LOAD;
                    end else if (r_cell == LAST_CELL) begin
                        w_state_n = IDLE;
                    end else begin
                        w_cell_n  = r_cell + CELL_W'(1);
                        w_bit_n   = '0;
                        w_state_n = FETCH;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

endmodule

// File: doc/charmatrix_engine.md
CHARMATRIX_ENGINE -- requirements
Module: charmatrix_engine

Interface
REQ-001 SHALL have parameter NUM_CHARS, default 4, number of character cells (1..16).
REQ-002 SHALL have parameter GLYPH_BITS, default 35, pixels per cell (5x7 matrix).
REQ-003 SHALL have parameter COLOR_W, default 24, pixel colour width (8-bit channels).
REQ-004 SHALL have ports clk input 1, single clock; rst_n input 1, asynchronous active-low reset.
REQ-005 SHALL have ports wr_valid input 1, wr_ready output 1, wr_char input 8, wr_color input 4: text write handshake.
REQ-006 SHALL have ports mode input 1 (0 = wrap, 1 = scroll) and clear input 1 (buffer clear pulse).
REQ-007 SHALL have ports bright input 3, right-shift applied to every channel (0 = full).
REQ-008 SHALL have ports refresh_req input 1, frame start pulse; busy output 1, frame in progress.
REQ-009 SHALL have ports glyph_addr output 8, glyph_data input GLYPH_BITS (combinational ROM, same cycle).
REQ-010 SHALL have ports color_addr output 4, color_data input COLOR_W (combinational ROM, same cycle).
REQ-011 SHALL have ports px_data output COLOR_W, px_valid output 1, px_ready input 1, px_last output 1: pixel stream to LED driver.

Function
REQ-012 SHALL hold NUM_CHARS entries {char[7:0], color[3:0]} and a write pointer wr_ptr.
REQ-013 SHALL drive wr_ready = !clear; a write SHALL complete on a cycle with wr_valid && wr_ready.
REQ-014 Wrap mode SHALL store at wr_ptr; wr_ptr SHALL increment and wrap NUM_CHARS-1 -> 0.
REQ-015 Scroll mode SHALL shift entry i+1 into i and store the new entry at NUM_CHARS-1; wr_ptr unchanged.
REQ-016 clear SHALL set every char to 8'h20, every color to 0, wr_ptr to 0, in one cycle; clear wins over a same-cycle write.
REQ-017 Writes SHALL be accepted at any time, including while busy.
REQ-018 FSM states SHALL be IDLE, FETCH, LOAD, SEND.
REQ-019 IDLE: refresh_req SHALL move to FETCH with cell = 0, bit = 0, busy = 1 the next cycle; refresh_req in any other state SHALL be ignored.
REQ-020 FETCH: SHALL drive glyph_addr/color_addr from the current cell and latch glyph_data and color_data into registers; go to LOAD.
REQ-021 LOAD: px_data SHALL be (glyph bit[bit] ? scaled colour : 0); px_valid = 1; px_last = 1 only for the last bit of the last cell; go to SEND.
REQ-022 Scaled colour SHALL be each 8-bit channel logically shifted right by bright, with no carry between channels.
REQ-023 SEND: px_data, px_valid, px_last SHALL stay stable until px_valid && px_ready; px_valid SHALL then drop for at least one cycle.
REQ-024 After handshake: bit < GLYPH_BITS-1 -> bit+1, LOAD; else last cell -> IDLE with busy = 0; else cell+1, bit = 0, FETCH.
REQ-025 Glyph and colour SHALL be latched once per cell; buffer writes during that cell SHALL take effect from the next cell or frame.
REQ-026 Frame latency SHALL be 3 cycles from refresh_req to the first px_valid, and 1 cycle from a handshake to the next px_valid within a cell.
REQ-027 mode and bright changes SHALL take effect on the next write or LOAD respectively.

Reset
REQ-028 On rst_n low: state IDLE, busy 0, px_valid 0, px_last 0, px_data 0, cell/bit/wr_ptr 0, chars 8'h20, colors 0.
REQ-029 Reset mid-frame SHALL abort the frame; px_valid SHALL be 0 while rst_n is low; no resumption after release.

Structure
REQ-030 Package charmatrix_pkg SHALL hold FSM state encoding, the 8'h20 blank-char constant and the channel-scaling function.
REQ-031 The text/colour buffer with wrap/scroll/clear logic SHALL be sub-module charmatrix_textbuf with a read port for cell index.

Verification
REQ-032 Wrap: write 'A','B','C','D','E' (colors 1..5), mode 0 -> buffer E,B,C,D with colors 5,2,3,4; wr_ptr = 1.
REQ-033 Scroll: same writes, mode 1 -> buffer B,C,D,E with colors 2,3,4,5.
REQ-034 Frame: refresh_req with px_ready held 1 -> exactly 140 handshakes, px_last only on the 140th, busy = 0 afterwards, first px_valid 3 cycles after refresh_req.
REQ-035 Backpressure: px_ready low for 10 cycles mid-cell -> px_data/px_last stable, no skipped or repeated pixels; colour 24'hFF8040 with bright = 2 -> 24'h3F2010.
REQ-036 Collisions: clear and wr_valid in the same cycle -> all cells 8'h20 and write not accepted; refresh_req while busy -> ignored, still 140 pixels.
REQ-037 Reset at pixel 50 -> px_valid 0 immediately; after release, the next refresh_req -> a full 140-pixel frame.
